// File: rtl/firebird7_in_gate1_data_mux_ctrl_pkg.sv
// Shared types and TDR field layout for the gate1 data mux IJTAG controller.
package firebird7_in_gate1_data_mux_ctrl_pkg;

  // Bit 2 of the encoding is the mux select, so ijtag_select comes straight
  // off a state flop and cannot glitch on state changes.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_WAIT    = 3'b001,
    ST_ABORT   = 3'b010,
    ST_ACTIVE  = 3'b100,
    ST_RELEASE = 3'b101
  } state_e;

  localparam int SEL_STATE_BIT = 2;

  // TDR layout: {ERR, EN, DATA[WIDTH-1:0]}
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int en_bit(int width);
    return width;
  endfunction

  function automatic int err_bit(int width);
    return width + 1;
  endfunction

  // One counter serves both the takeover timeout and the release guard.
  function automatic int cnt_width(int timeout_cycles, int guard_cycles);
    int top;
    top = (timeout_cycles > guard_cycles) ? timeout_cycles : guard_cycles;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_data_mux_tdr.sv
// WIDTH+2 bit IJTAG TDR with capture/shift/update and the shadow data register.
module firebird7_in_gate1_data_mux_tdr
  import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH = 19
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic             cap_err,
  input  logic             cap_select,
  output logic             ijtag_so,
  output logic [WIDTH-1:0] shadow_data,
  output logic             takeover_en,
  output logic             err_clr
);

  localparam int TDR_W   = WIDTH + 2;
  localparam int DATA_LO = data_lsb();
  localparam int EN_IDX  = en_bit(WIDTH);
  localparam int ERR_IDX = err_bit(WIDTH);

  logic [TDR_W-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             takeover_en_q, takeover_en_d;

  // TDR operation select: capture beats shift beats update, all gated by sel.
  always_comb begin
    shift_reg_d   = shift_reg_q;
    shadow_d      = shadow_q;
    takeover_en_d = takeover_en_q;
    err_clr       = 1'b0;
    if (ijtag_sel) begin
      if (ijtag_ce) begin
        shift_reg_d = {cap_err, cap_select, functional_data_in};
      end else if (ijtag_se) begin
        shift_reg_d = {ijtag_si, shift_reg_q[TDR_W-1:1]};
      end else if (ijtag_ue) begin
        shadow_d      = shift_reg_q[EN_IDX-1:DATA_LO];
        takeover_en_d = shift_reg_q[EN_IDX];
        err_clr       = shift_reg_q[ERR_IDX];
      end
    end
  end

  // TDR and shadow registers.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      shift_reg_q   <= '0;
      shadow_q      <= '0;
      takeover_en_q <= 1'b0;
    end else begin
      shift_reg_q   <= shift_reg_d;
      shadow_q      <= shadow_d;
      takeover_en_q <= takeover_en_d;
    end
  end

  assign ijtag_so    = shift_reg_q[0];
  assign shadow_data = shadow_q;
  assign takeover_en = takeover_en_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG-side controller for the gate1 data mux: TDR plus takeover handshake FSM.
// Optional build macro FIREBIRD7_DATA_MUX_CTRL_FORCE_EN: a WAIT timeout forces
// the takeover (ACTIVE) instead of aborting; ABORT becomes unreachable.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | functional side owns the mux, waiting for takeover_en
// WAIT    | takeover requested, waiting for func_idle (timeout counted)
// ACTIVE  | IJTAG owns the mux (select=1)
// RELEASE | release requested, select held for the guard interval
// ABORT   | timeout without func_idle; parked until takeover_en drops
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_data_mux_ctrl_pkg::*;
#(
  parameter int WIDTH          = 19,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  input  logic             func_idle,
  output logic [WIDTH-1:0] ijtag_data_in_out,
  output logic             ijtag_select,
  output logic             takeover_err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES, GUARD_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
  // A zero guard still spends one cycle in RELEASE.
  localparam logic [CNT_W-1:0] GUARD_TC =
    CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              takeover_err_q, takeover_err_d;
  logic              takeover_en;
  logic              err_clr;

  firebird7_in_gate1_data_mux_tdr #(
    .WIDTH(WIDTH)
  ) u_tdr (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .ijtag_sel         (ijtag_sel),
    .ijtag_ce          (ijtag_ce),
    .ijtag_se          (ijtag_se),
    .ijtag_ue          (ijtag_ue),
    .ijtag_si          (ijtag_si),
    .functional_data_in(functional_data_in),
    .cap_err           (takeover_err_q),
    .cap_select        (ijtag_select),
    .ijtag_so          (ijtag_so),
    .shadow_data       (ijtag_data_in_out),
    .takeover_en       (takeover_en),
    .err_clr           (err_clr)
  );

  // Next-state, counter and sticky error; a timeout set wins over a same-cycle clear.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    takeover_err_d = takeover_err_q;
    if (err_clr) begin
      takeover_err_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (takeover_en) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!takeover_en) begin
          state_d = ST_IDLE;
        end else if (func_idle) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == TIMEOUT_TC) begin
          takeover_err_d = 1'b1;
`ifdef FIREBIRD7_DATA_MUX_CTRL_FORCE_EN
          state_d = ST_ACTIVE;
`else
          state_d = ST_ABORT;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!takeover_en) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (takeover_en) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q >= GUARD_TC) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!takeover_en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and error registers.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      takeover_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      takeover_err_q <= takeover_err_d;
    end
  end

  assign ijtag_select = state_q[SEL_STATE_BIT];
  assign takeover_err = takeover_err_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Self-checking bench for the gate1 data mux IJTAG controller.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int W = 19;
  localparam int T = 8;
  localparam int G = 2;
  localparam int G_EFF = (G == 0) ? 1 : G;
`ifdef FIREBIRD7_DATA_MUX_CTRL_FORCE_EN
  localparam bit FORCE = 1'b1;
`else
  localparam bit FORCE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel, ce, se, ue, si, so;
  logic         fidle;
  logic [W-1:0] fdata, dout;
  logic         sel_o, err_o;

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .WIDTH(W), .TIMEOUT_CYCLES(T), .GUARD_CYCLES(G)
  ) dut (
    .ijtag_tck(clk), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
    .functional_data_in(fdata), .func_idle(fidle),
    .ijtag_data_in_out(dout), .ijtag_select(sel_o), .takeover_err(err_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference view of the TDR: shift register contents and shadow value.
  logic [W+1:0] m_sr;
  logic [W-1:0] m_shadow;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift a full vector in (LSB first), then one update cycle.
  task automatic scan_write(input logic [W+1:0] v);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      si = v[i];
      tick();
    end
    se = 1'b0;
    ue = 1'b1;
    tick();
    ue = 1'b0;
    si = 1'b0;
    m_sr     = v;
    m_shadow = v[W-1:0];
  endtask

  // Shift the register out while shifting fill in; no update.
  task automatic scan_read(output logic [W+1:0] got, input logic [W+1:0] fill);
    sel = 1'b1;
    se  = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      got[i] = so;
      si = fill[i];
      tick();
    end
    se = 1'b0;
    si = 1'b0;
    m_sr = fill;
  endtask

  task automatic capture();
    sel = 1'b1;
    ce  = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] got;
    logic [W+1:0] fill;
    logic [W-1:0] rdata;
    int d, t_act;
    bit timeout, exp_sel, exp_err;

    rst_n = 1'b0; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    fidle = 1'b0; fdata = '0;
    m_sr = '0; m_shadow = '0;
    #12;
    check("reset_select", sel_o, 0);
    check("reset_err", err_o, 0);
    check("reset_data", dout, 0);
    check("reset_so", so, 0);
    rst_n = 1'b1;
    tick();

    // Takeover with func_idle already high.
    fidle = 1'b1;
    scan_write({1'b0, 1'b1, 19'h5A5A5});
    check("shadow_after_ue", dout, 19'h5A5A5);
    check("sel_at_ue", sel_o, 0);
    tick();
    check("sel_in_wait", sel_o, 0);
    tick();
    check("sel_active", sel_o, 1);

    // Release with guard interval: ACTIVE one cycle, then G_EFF in RELEASE.
    scan_write({1'b0, 1'b0, 19'h12345});
    for (int j = 0; j <= G_EFF + 2; j++) begin
      check("guard_hold", sel_o, (j <= G_EFF) ? 1 : 0);
      tick();
    end

    // Re-enable inside the guard window: select must never drop.
    scan_write({1'b1, 1'b1, 19'h0F0F0});
    tick();
    tick();
    check("reacquire", sel_o, 1);
    scan_write({1'b1, 1'b0, 19'h33333});
    check("reassert_k0", sel_o, 1);
    se = 1'b1; si = 1'b0;
    tick();
    se = 1'b0;
    m_sr = {1'b0, m_sr[W+1:1]};
    check("reassert_k1", sel_o, 1);
    ue = 1'b1;
    tick();
    ue = 1'b0;
    m_shadow = m_sr[W-1:0];
    for (int j = 0; j < 6; j++) begin
      check("reassert_hold", sel_o, 1);
      tick();
    end
    check("reassert_shadow", dout, m_shadow);

    // Capture priority over shift and update.
    fill = {1'b0, 1'b1, W'($urandom())};
    scan_read(got, fill);
    fdata = W'($urandom());
    sel = 1'b1; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    check("prio_shadow_kept", dout, m_shadow);
    check("prio_sel_kept", sel_o, 1);
    fill = {1'b1, 1'b0, W'($urandom())};
    scan_read(got, fill);
    check("prio_capture", got, {1'b0, 1'b1, fdata});

    // Deselected: no register changes at all.
    sel = 1'b0; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    fdata = W'($urandom());
    tick(); tick(); tick();
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    check("nosel_shadow", dout, m_shadow);
    check("nosel_sel", sel_o, 1);
    scan_read(got, '0);
    check("nosel_sr_kept", got, fill);

    // Back to IDLE.
    scan_write({1'b0, 1'b0, 19'h0});
    for (int j = 0; j < 5; j++) tick();
    check("idle_again", sel_o, 0);

    // Random data through shadow and capture path (no takeover).
    for (int it = 0; it < 6; it++) begin
      rdata = W'($urandom());
      scan_write({1'b0, 1'b0, rdata});
      check("rand_shadow", dout, rdata);
      fdata = W'($urandom());
      capture();
      scan_read(got, {W'($urandom()), 2'b00});
      check("rand_capture", got, {1'b0, 1'b0, fdata});
    end

    // Random func_idle arrival vs. timeout. d is the cycle after ue at which
    // func_idle is driven high; it is first sampled one edge later.
    for (int it = 0; it < 8; it++) begin
      d = (it == 0) ? 20 : int'($urandom_range(1, 12));
      t_act = (d + 1 > 2) ? d + 1 : 2;
      timeout = (t_act > T + 1);
      fidle = 1'b0;
      scan_write({1'b0, 1'b1, W'($urandom())});
      for (int j = 0; j <= 14; j++) begin
        exp_sel = timeout ? (FORCE && j >= T + 1) : (j >= t_act);
        exp_err = timeout && (j >= T + 1);
        check("to_select", sel_o, exp_sel);
        check("to_err", err_o, exp_err);
        fidle = (j >= d);
        tick();
      end
      fdata = W'($urandom());
      capture();
      scan_read(got, '0);
      check("to_capture", got, {exp_err, exp_sel, fdata});
      scan_write({1'b1, 1'b0, 19'h0});
      check("err_cleared", err_o, 0);
      for (int j = 0; j < 5; j++) tick();
      check("to_idle", sel_o, 0);
    end

    // Asynchronous reset while ACTIVE.
    fidle = 1'b1;
    scan_write({1'b0, 1'b1, 19'h7FFFF});
    tick();
    tick();
    check("pre_reset_sel", sel_o, 1);
    check("pre_reset_data", dout, 19'h7FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", sel_o, 0);
    check("async_data", dout, 0);
    check("async_err", err_o, 0);
    #3;
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
